// File: rtl/aig_mix_sched.sv
// aig_mix_sched
//
// Round-robin scheduler that time-shares one external 96-in / 48-out
// datapath among NREQ requesters. One operand vector is accepted at a time,
// registered onto dp_in, and held there until the next grant. After DP_LAT
// cycles the 48-bit result is captured and returned on the response channel,
// tagged with the index of the requester that supplied the operand.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high in the preceding cycle. On the request side req_ready is a
// one-hot grant that is only ever raised in IDLE. On the response side
// rsp_valid stays high, with rsp_data/rsp_id stable, until rsp_ready is seen;
// rsp_ready has no effect while rsp_valid is low.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   req_valid      per-requester request valid            [NREQ]
//   req_data       packed operands, requester i at [96*i +: 96]
//   req_ready      one-hot accept strobe, zero outside IDLE [NREQ]
//   dp_in          registered operand to the shared datapath [96]
//   dp_out         datapath result                         [48]
//   rsp_valid      result available
//   rsp_ready      consumer accepts result
//   rsp_data       captured result                         [48]
//   rsp_id         owner of rsp_data                       [IDW]
//   busy           high whenever the FSM is not in IDLE
//   txn_count      completed-response counter, wraps       [16]
//   state_o        current FSM state for observation       [2]

module aig_mix_sched #(
  parameter int NREQ   = 4,
  parameter int IDW    = 2,
  parameter int DP_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*96-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic [95:0]          dp_in,
  input  logic [47:0]          dp_out,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [47:0]          rsp_data,
  output logic [IDW-1:0]       rsp_id,
  output logic                 busy,
  output logic [15:0]          txn_count,
  output logic [1:0]           state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [95:0]      dp_in_q, dp_in_d;
  logic [47:0]      rsp_data_q, rsp_data_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [15:0]      txn_q, txn_d;

  // Grant search: first valid requester at or above ptr, wrapping modulo NREQ.
  logic             gnt_found;
  logic [IDW-1:0]   gnt_idx;
  logic [95:0]      gnt_data;

  always_comb begin
    int unsigned j;
    j         = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_data  = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr_q) + k) % NREQ;
      if (!gnt_found && req_valid[j]) begin
        gnt_found = 1'b1;
        gnt_idx   = j[IDW-1:0];
        gnt_data  = req_data[j*96 +: 96];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    dp_in_d    = dp_in_q;
    rsp_data_d = rsp_data_q;
    id_d       = id_q;
    txn_d      = txn_q;
    req_ready  = '0;
    case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          req_ready[gnt_idx] = 1'b1;
          dp_in_d            = gnt_data;
          id_d               = gnt_idx;
          cnt_d              = 4'(DP_LAT);
          state_d            = S_WAIT;
        end
      end
      S_WAIT: begin
        // dp_out is looked at only here, once the latency has elapsed.
        if (cnt_q == 4'd0) begin
          rsp_data_d = dp_out;
          state_d    = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          txn_d   = txn_q + 16'd1;
          // Requester after the one just served gets top priority next.
          ptr_d   = (int'(id_q) == NREQ - 1) ? '0 : id_q + 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      dp_in_q    <= '0;
      rsp_data_q <= '0;
      id_q       <= '0;
      txn_q      <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      dp_in_q    <= dp_in_d;
      rsp_data_q <= rsp_data_d;
      id_q       <= id_d;
      txn_q      <= txn_d;
    end
  end

  assign dp_in     = dp_in_q;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = id_q;
  assign busy      = (state_q != S_IDLE);
  assign txn_count = txn_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_aig_mix_sched.sv
// Bench for aig_mix_sched. Four scheduler instances with DP_LAT = 1, 2, 0, 15
// each drive their own stub datapath (DP_LAT-deep pipeline computing
// dp_in[47:0] ^ dp_in[95:48]). Only the selected instance sees requests.
module tb_aig_mix_sched;

  localparam int NI = 4;

  function automatic int lat_of(input int k);
    case (k)
      0:       return 1;
      1:       return 2;
      2:       return 0;
      default: return 15;
    endcase
  endfunction

  // clock / reset / shared stimulus
  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [383:0] req_data;
  logic         rsp_ready;
  int           sel;

  always #5 clk = ~clk;

  logic [3:0]  rv_a    [NI];
  logic [3:0]  ready_a [NI];
  logic [95:0] dpin_a  [NI];
  logic [47:0] dpout_a [NI];
  logic        rspv_a  [NI];
  logic [47:0] rspd_a  [NI];
  logic [1:0]  rspid_a [NI];
  logic        busy_a  [NI];
  logic [15:0] txn_a   [NI];
  logic [1:0]  st_a    [NI];

  for (genvar k = 0; k < NI; k++) begin : g_inst
    localparam int L = lat_of(k);
    assign rv_a[k] = (sel == k) ? req_valid : 4'b0000;

    aig_mix_sched #(.NREQ(4), .IDW(2), .DP_LAT(L)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (rv_a[k]),
      .req_data  (req_data),
      .req_ready (ready_a[k]),
      .dp_in     (dpin_a[k]),
      .dp_out    (dpout_a[k]),
      .rsp_valid (rspv_a[k]),
      .rsp_ready (rsp_ready),
      .rsp_data  (rspd_a[k]),
      .rsp_id    (rspid_a[k]),
      .busy      (busy_a[k]),
      .txn_count (txn_a[k]),
      .state_o   (st_a[k])
    );

    if (L == 0) begin : g_comb
      assign dpout_a[k] = dpin_a[k][47:0] ^ dpin_a[k][95:48];
    end else begin : g_pipe
      logic [47:0] pipe [L];
      always @(posedge clk) begin
        pipe[0] <= dpin_a[k][47:0] ^ dpin_a[k][95:48];
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
      end
      assign dpout_a[k] = pipe[L-1];
    end
  end

  logic [3:0]  cur_ready;
  logic [95:0] cur_dpin;
  logic        cur_rspv;
  logic [47:0] cur_rspd;
  logic [1:0]  cur_rspid;
  logic        cur_busy;
  logic [15:0] cur_txn;
  logic [1:0]  cur_st;
  assign cur_ready = ready_a[sel];
  assign cur_dpin  = dpin_a[sel];
  assign cur_rspv  = rspv_a[sel];
  assign cur_rspd  = rspd_a[sel];
  assign cur_rspid = rspid_a[sel];
  assign cur_busy  = busy_a[sel];
  assign cur_txn   = txn_a[sel];
  assign cur_st    = st_a[sel];

  // operands and hand-computed xor results
  localparam logic [95:0] OP0 = {48'h0000_0000_00F0, 48'h0000_0000_000F};
  localparam logic [95:0] OP1 = {48'hAAAA_AAAA_AAAA, 48'h5555_5555_5555};
  localparam logic [95:0] OP2 = {48'h1234_5678_9ABC, 48'h1234_5678_9ABC};
  localparam logic [95:0] OP3 = {48'hF0F0_F0F0_F0F0, 48'hFF00_FF00_FF00};
  localparam logic [47:0] R0  = 48'h0000_0000_00FF;
  localparam logic [47:0] R1  = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] R2  = 48'h0000_0000_0000;
  localparam logic [47:0] R3  = 48'h0FF0_0FF0_0FF0;

  // scoreboard
  logic [49:0] exp_q[$];
  int          acc_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          last_acc = 0;
  logic        prev_v   = 1'b0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: accepts, response latency, popped responses
  always @(negedge clk) begin
    logic [49:0] e;
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if ((cur_ready & req_valid) != 4'b0000) begin
        last_acc = cyc + 1;
        acc_q.push_back(cyc + 1);
      end
      if (cur_rspv && !prev_v)
        check("rsp_latency", 96'(cyc - last_acc), 96'(1 + lat_of(sel)));
      if (cur_rspv && rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rsp: got id=%0d data=%h expected no response", cur_rspid, cur_rspd);
        end else begin
          e = exp_q.pop_front();
          check("rsp_id", 96'(cur_rspid), 96'(e[49:48]));
          check("rsp_data", 96'(cur_rspd), 96'(e[47:0]));
        end
      end
      prev_v = cur_rspv;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && !cur_busy) break;
      tick();
    end
    if (i == budget) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_done: got timeout after %0d cycles expected drained scoreboard", budget);
    end
  endtask

  task automatic check_reset_vals();
    check("rst_req_ready", 96'(cur_ready), 96'(0));
    check("rst_rsp_valid", 96'(cur_rspv), 96'(0));
    check("rst_busy",      96'(cur_busy), 96'(0));
    check("rst_txn_count", 96'(cur_txn), 96'(0));
    check("rst_dp_in",     cur_dpin, 96'(0));
    check("rst_rsp_data",  96'(cur_rspd), 96'(0));
    check("rst_rsp_id",    96'(cur_rspid), 96'(0));
    check("rst_state",     96'(cur_st), 96'(0));
  endtask

  // single transaction from requester r; dp_in checked through WAIT
  task automatic run_single(input int r, input logic [95:0] op, input logic [47:0] res);
    logic [3:0] oh;
    oh = 4'b0001 << r;
    exp_q.push_back({2'(r), res});
    req_valid = oh;
    @(negedge clk);
    check("grant_onehot", 96'(cur_ready), 96'(oh));
    tick();
    req_valid = 4'b0000;
    @(negedge clk);
    check("ready_one_cycle", 96'(cur_ready), 96'(0));
    check("busy_after_accept", 96'(cur_busy), 96'(1));
    for (int i = 0; i < 40 && cur_st == 2'd1; i++) begin
      check("dp_in_hold", cur_dpin, op);
      tick();
      @(negedge clk);
    end
    wait_done(40);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 4'b0000;
    req_data  = {OP3, OP2, OP1, OP0};
    rsp_ready = 1'b1;
    sel       = 0;
    repeat (3) tick();
    rst = 1'b0;

    // reset state of every instance
    for (int k = 0; k < NI; k++) begin
      sel = k;
      @(negedge clk);
      check_reset_vals();
    end
    tick();

    // single transaction, DP_LAT=1, requester 2
    sel = 0;
    req_data = {OP3, {48'hFFFF_0000_FFFF, 48'h0000_FFFF_0000}, OP1, OP0};
    run_single(2, {48'hFFFF_0000_FFFF, 48'h0000_FFFF_0000}, 48'hFFFF_FFFF_FFFF);
    check("txn_single", 96'(cur_txn), 96'(1));
    req_data = {OP3, OP2, OP1, OP0};

    // all requesters valid, DP_LAT=2: order 0,1,2,3,0,1,2,3, 5 cycles apart
    sel = 1;
    acc_q.delete();
    for (int n = 0; n < 8; n++) begin
      case (n % 4)
        0: exp_q.push_back({2'd0, R0});
        1: exp_q.push_back({2'd1, R1});
        2: exp_q.push_back({2'd2, R2});
        default: exp_q.push_back({2'd3, R3});
      endcase
    end
    req_valid = 4'b1111;
    wait_done(100);
    req_valid = 4'b0000;
    check("rr_accepts", 96'(acc_q.size()), 96'(8));
    for (int n = 1; n < 8 && n < acc_q.size(); n++)
      check("rr_spacing", 96'(acc_q[n] - acc_q[n-1]), 96'(5));
    check("txn_rr", 96'(cur_txn), 96'(8));

    // back-pressure: rsp_ready low for 6 cycles in RESP
    exp_q.push_back({2'd1, R1});
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b0000;
    rsp_ready = 1'b0;
    for (int i = 0; i < 20 && !cur_rspv; i++) tick();
    req_valid = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", 96'(cur_rspv), 96'(1));
      check("bp_rsp_data",  96'(cur_rspd), 96'(R1));
      check("bp_rsp_id",    96'(cur_rspid), 96'(1));
      check("bp_req_ready", 96'(cur_ready), 96'(0));
      check("bp_busy",      96'(cur_busy), 96'(1));
      tick();
    end
    rsp_ready = 1'b1;
    req_valid = 4'b0000;
    tick();
    check("bp_done_busy", 96'(cur_busy), 96'(0));
    check("bp_txn", 96'(cur_txn), 96'(9));
    check("bp_drained", 96'(exp_q.size()), 96'(0));

    // DP_LAT boundaries
    sel = 2;
    run_single(0, OP0, R0);
    check("txn_lat0", 96'(cur_txn), 96'(1));
    sel = 3;
    run_single(1, OP1, R1);
    check("txn_lat15", 96'(cur_txn), 96'(1));

    // txn_count wrap on the DP_LAT=0 instance
    sel = 2;
    force g_inst[2].u_dut.txn_q = 16'hFFFF;
    tick();
    tick();
    release g_inst[2].u_dut.txn_q;
    @(negedge clk);
    check("txn_preset", 96'(cur_txn), 96'(16'hFFFF));
    tick();
    run_single(3, OP3, R3);
    check("txn_wrap", 96'(cur_txn), 96'(0));

    // reset while requester 3 is in WAIT (ptr is 2 beforehand)
    sel = 3;
    req_valid = 4'b1000;
    tick();
    req_valid = 4'b0000;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals();
    repeat (20) tick();
    check("rst_no_rsp", 96'(cur_rspv), 96'(0));
    exp_q.push_back({2'd1, R1});
    req_valid = 4'b1010;
    @(negedge clk);
    check("rst_grant_from0", 96'(cur_ready), 96'(4'b0010));
    tick();
    req_valid = 4'b0000;
    wait_done(40);
    check("txn_after_rst", 96'(cur_txn), 96'(1));

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
